// File: rtl/riscv_id_stage_hs.sv
// Decode stage with valid/ready handshake, two-deep storage (output + skid),
// flush, XLEN-generic immediates, optional M-extension and illegal detection.
module riscv_id_stage_hs #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_inst,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic            i_flush,
    input  logic            i_id_ready,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [31:0]     o_id_inst,
    output logic [4:0]      o_id_rs1_addr,
    output logic [4:0]      o_id_rs2_addr,
    output logic [4:0]      o_id_rd_addr,
    output logic [XLEN-1:0] o_id_imm,
    output logic [4:0]      o_id_alu_op,
    output logic            o_id_illegal
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // payload = {pc, inst, imm, alu_op, illegal}
    localparam int PW = XLEN + 32 + XLEN + 5 + 1;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_dec_imm;
    logic [4:0]      w_dec_alu_op;
    logic            w_dec_illegal;
    logic [4:0]      w_f3_alu_op;
    logic [PW-1:0]   w_push_data;
    logic            w_push;
    logic            w_pop;

    logic            r_out_valid;
    logic            r_skd_valid;
    logic [PW-1:0]   r_out_data;
    logic [PW-1:0]   r_skd_data;

    assign w_opcode = i_if_inst[6:0];
    assign w_funct3 = i_if_inst[14:12];
    assign w_funct7 = i_if_inst[31:25];

    // Base ALU op selected by funct3, shared by OP and OP-IMM (SRL default for 101)
    always_comb begin
        w_f3_alu_op = 5'd0;
        case (w_funct3)
            3'b000:  w_f3_alu_op = 5'd0;  // ADD
            3'b001:  w_f3_alu_op = 5'd5;  // SLL
            3'b010:  w_f3_alu_op = 5'd8;  // SLT
            3'b011:  w_f3_alu_op = 5'd9;  // SLTU
            3'b100:  w_f3_alu_op = 5'd4;  // XOR
            3'b101:  w_f3_alu_op = 5'd6;  // SRL
            3'b110:  w_f3_alu_op = 5'd3;  // OR
            default: w_f3_alu_op = 5'd2;  // AND
        endcase
    end

    // Full decode of the incoming instruction before it is captured
    always_comb begin
        w_dec_imm     = '0;
        w_dec_alu_op  = 5'd0;
        w_dec_illegal = (i_if_inst[1:0] != 2'b11);
        case (w_opcode)
            OPC_LOAD, OPC_JALR: begin
                w_dec_imm = {{(XLEN-12){i_if_inst[31]}}, i_if_inst[31:20]};
            end
            OPC_OPIMM: begin
                w_dec_imm    = {{(XLEN-12){i_if_inst[31]}}, i_if_inst[31:20]};
                w_dec_alu_op = w_f3_alu_op;
                if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) begin
                    w_dec_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == 7'b0100000)
                        w_dec_alu_op = 5'd7;  // SRAI
                    else if (w_funct7 != 7'b0000000)
                        w_dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                w_dec_imm = {{(XLEN-12){i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
            end
            OPC_BRANCH: begin
                w_dec_imm = {{(XLEN-12){i_if_inst[31]}}, i_if_inst[7], i_if_inst[30:25],
                             i_if_inst[11:8], 1'b0};
            end
            OPC_JAL: begin
                w_dec_imm = {{(XLEN-20){i_if_inst[31]}}, i_if_inst[19:12], i_if_inst[20],
                             i_if_inst[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                // sign-extend the 20-bit field, then shift it into place
                w_dec_imm = {{(XLEN-20){i_if_inst[31]}}, i_if_inst[31:12]} << 12;
            end
            OPC_OP: begin
                case (w_funct7)
                    7'b0000000: w_dec_alu_op = w_f3_alu_op;
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)
                            w_dec_alu_op = 5'd1;  // SUB
                        else if (w_funct3 == 3'b101)
                            w_dec_alu_op = 5'd7;  // SRA
                        else
                            w_dec_illegal = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_M)
                            w_dec_alu_op = {2'b10, w_funct3};  // MUL..REMU
                        else
                            w_dec_illegal = 1'b1;
                    end
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            OPC_MISC, OPC_SYSTEM: ;
            default: w_dec_illegal = 1'b1;
        endcase
        if (w_dec_illegal) begin
            w_dec_imm    = '0;
            w_dec_alu_op = 5'd0;
        end
    end

    assign o_if_ready  = !r_skd_valid;
    assign w_push      = i_if_valid & o_if_ready;
    assign w_pop       = r_out_valid & i_id_ready;
    assign w_push_data = {i_if_pc, i_if_inst, w_dec_imm, w_dec_alu_op, w_dec_illegal};

    // Occupancy of the output slot and skid slot; flush empties both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_skd_valid <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_skd_valid <= 1'b0;
        end else if (!r_out_valid || w_pop) begin
            if (r_skd_valid) begin
                r_out_valid <= 1'b1;
                r_skd_valid <= w_push;
            end else begin
                r_out_valid <= w_push;
            end
        end else if (w_push) begin
            r_skd_valid <= 1'b1;
        end
    end

    // Payload registers; contents only matter where the matching valid is set
    always_ff @(posedge clk) begin
        if (!r_out_valid || w_pop) begin
            r_out_data <= r_skd_valid ? r_skd_data : w_push_data;
            r_skd_data <= w_push_data;
        end else if (w_push) begin
            r_skd_data <= w_push_data;
        end
    end

    assign o_id_valid    = r_out_valid;
    assign o_id_pc       = r_out_data[PW-1 -: XLEN];
    assign o_id_inst     = r_out_data[XLEN+5+1 +: 32];
    assign o_id_imm      = r_out_data[5+1 +: XLEN];
    assign o_id_alu_op   = r_out_data[1 +: 5];
    assign o_id_illegal  = r_out_data[0];
    assign o_id_rs1_addr = o_id_inst[19:15];
    assign o_id_rs2_addr = o_id_inst[24:20];
    assign o_id_rd_addr  = o_id_inst[11:7];

endmodule
